kgp_regfile: RTL and testbench

- 32 x 32-bit general-purpose register file for the KGP-RISC single-cycle datapath.
- Sits directly downstream of the 32-bit 2:1 write-back mux; wr_data is that mux's output (ALU result vs. memory load data).
- Supplies the rs and rt operands to the ALU operand stage.
- Has a dedicated link-write path that puts the return address into $31 for call instructions, and a debug read port for benches.

---
 rtl/kgp_regfile_pkg.sv | 14 +
 rtl/kgp_regfile_rdport.sv | 37 +++
 rtl/kgp_regfile.sv | 91 +++++++++
 tb/tb_kgp_regfile.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/kgp_regfile_pkg.sv
// Shared definitions for the KGP-RISC register file: widths, fixed register
// indices and the reset value.
package kgp_regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    // Hard-wired zero register and the link (return address) register.
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 31;

    localparam logic [DATA_W-1:0] RESET_VAL = '0;

endpackage

// File: rtl/kgp_regfile_rdport.sv
// One combinational read port: selects a stored register, optionally forwards
// the write-back or link data being written this cycle, and forces $0 to zero.
module kgp_regfile_rdport
    import kgp_regfile_pkg::*;
#(
    parameter int unsigned DW     = DATA_W,
    parameter int unsigned AW     = ADDR_W,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned BYPASS = 0
) (
    input  logic [AW-1:0]            addr,
    input  logic [NREGS-1:0][DW-1:0] regs,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     link_en,
    input  logic [DW-1:0]            link_data,
    output logic [DW-1:0]            data
);

    // Read mux; link forwarding is applied last so it wins over write-back on $31.
    always_comb begin
        data = regs[addr];
        if (BYPASS != 0) begin
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end
            if (link_en && (addr == AW'(REG_RA))) begin
                data = link_data;
            end
        end
        if (addr == AW'(REG_ZERO)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/kgp_regfile.sv
// 32 x 32-bit register file with two operand read ports, a debug read port,
// a write-back port and a dedicated link write into $31.
module kgp_regfile
    import kgp_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = kgp_regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W   = kgp_regfile_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned BYPASS   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    // Storage update; the link write is issued last so it overrides a
    // write-back that also targets $31.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= {NUM_REGS{DATA_W'(RESET_VAL)}};
        end else begin
            if (wr_en && (wr_addr != ADDR_W'(REG_ZERO))) begin
                regs[wr_addr] <= wr_data;
            end
            if (link_en) begin
                regs[REG_RA] <= link_data;
            end
        end
    end

    kgp_regfile_rdport #(
        .DW     (DATA_W),
        .AW     (ADDR_W),
        .NREGS  (NUM_REGS),
        .BYPASS (BYPASS)
    ) u_rs_port (
        .addr      (rs_addr),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .data      (rs_data)
    );

    kgp_regfile_rdport #(
        .DW     (DATA_W),
        .AW     (ADDR_W),
        .NREGS  (NUM_REGS),
        .BYPASS (BYPASS)
    ) u_rt_port (
        .addr      (rt_addr),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .data      (rt_data)
    );

    kgp_regfile_rdport #(
        .DW     (DATA_W),
        .AW     (ADDR_W),
        .NREGS  (NUM_REGS),
        .BYPASS (BYPASS)
    ) u_dbg_port (
        .addr      (dbg_addr),
        .regs      (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .data      (dbg_data)
    );

endmodule

// File: tb/tb_kgp_regfile.sv
// Self-checking bench: one BYPASS=0 and one BYPASS=1 instance share stimulus
// and are compared against a simple array model of the register file.
module tb_kgp_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic        wr_en, link_en;
    logic [31:0] wr_data, link_data;
    logic [31:0] rs0, rt0, dbg0, rs1, rt1, dbg1;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    kgp_regfile #(.BYPASS(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs0),
        .rt_data   (rt0),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg0)
    );

    kgp_regfile #(.BYPASS(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs1),
        .rt_data   (rt1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .link_en   (link_en),
        .link_data (link_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected read value: $0 is zero, bypass forwards link before write-back.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && link_en && a == 5'd31) return link_data;
        if (byp && wr_en && a == wr_addr) return wr_data;
        return model[a];
    endfunction

    // Apply the current inputs' effect to the model, then clock.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else begin
            if (wr_en && wr_addr != 5'd0) model[wr_addr] = wr_data;
            if (link_en) model[31] = link_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rs0"},  rs0,  exp_rd(rs_addr, 1'b0));
        check({tag, ".rt0"},  rt0,  exp_rd(rt_addr, 1'b0));
        check({tag, ".dbg0"}, dbg0, exp_rd(dbg_addr, 1'b0));
        check({tag, ".rs1"},  rs1,  exp_rd(rs_addr, 1'b1));
        check({tag, ".rt1"},  rt1,  exp_rd(rt_addr, 1'b1));
        check({tag, ".dbg1"}, dbg1, exp_rd(dbg_addr, 1'b1));
    endtask

    task automatic set_wr(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic le, input logic [31:0] ld);
        wr_en = we; wr_addr = wa; wr_data = wd; link_en = le; link_data = ld;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        rs_addr = a; rt_addr = b; dbg_addr = d;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_wr(1'b1, 5'd4, 32'h1234_5678, 1'b1, 32'hAAAA_0000);
        set_rd(5'd0, 5'd0, 5'd0);
        tick();
        rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);

        // Reset then read.
        set_rd(5'd0, 5'd5, 5'd31);
        check("rst.rs0", rs0, 32'd0); check("rst.rt5", rt0, 32'd0); check("rst.dbg31", dbg0, 32'd0);
        set_rd(5'd31, 5'd0, 5'd4);
        check("rst.rs31", rs1, 32'd0); check("rst.rt0", rt1, 32'd0); check("rst.dbg4", dbg1, 32'd0);

        // Basic write/read.
        set_wr(1'b1, 5'd5, 32'd52, 1'b0, 32'd0);
        tick();
        set_wr(1'b1, 5'd6, 32'd38, 1'b0, 32'd0);
        tick();
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        set_rd(5'd5, 5'd6, 5'd5);
        check("wr.rs5", rs0, 32'd52); check("wr.rt6", rt0, 32'd38); check("wr.rs5b", rs1, 32'd52);
        set_rd(5'd6, 5'd6, 5'd6);
        check("wr.same_port", rs0, rt0); check("wr.same_val", rt0, 32'd38);

        // $0 protection, including same-cycle bypass.
        set_wr(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);
        set_rd(5'd0, 5'd0, 5'd0);
        check("z.byp_dbg", dbg1, 32'd0); check("z.byp_rs", rs1, 32'd0);
        tick();
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        #1;
        check("z.dbg0", dbg0, 32'd0); check("z.dbg1", dbg1, 32'd0);

        // Link collision on $31, then parallel link and write-back.
        set_wr(1'b1, 5'd31, 32'd100, 1'b1, 32'd200);
        set_rd(5'd31, 5'd31, 5'd31);
        check("lk.byp_prio", rs1, 32'd200); check("lk.nobyp_old", rs0, 32'd0);
        tick();
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        #1;
        check("lk.col31", dbg0, 32'd200);
        set_wr(1'b1, 5'd7, 32'd100, 1'b1, 32'd204);
        tick();
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        set_rd(5'd7, 5'd31, 5'd7);
        check("lk.r7", rs0, 32'd100); check("lk.r31", rt0, 32'd204); check("lk.r7b", dbg1, 32'd100);

        // Same-cycle read of write target.
        set_wr(1'b1, 5'd9, 32'd11, 1'b0, 32'd0);
        tick();
        set_wr(1'b1, 5'd9, 32'd77, 1'b0, 32'd0);
        set_rd(5'd9, 5'd0, 5'd9);
        check("rw.old0", rs0, 32'd11); check("rw.byp1", rs1, 32'd77); check("rw.dbgbyp", dbg1, 32'd77);
        tick();
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        #1;
        check("rw.new0", rs0, 32'd77);

        // Mid-program reset ignores a concurrent write.
        set_wr(1'b1, 5'd3, 32'd15, 1'b1, 32'd400);
        tick();
        rst = 1'b1;
        set_wr(1'b1, 5'd3, 32'd99, 1'b1, 32'd500);
        tick();
        rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        set_rd(5'd3, 5'd31, 5'd7);
        check("mr.r3", rs0, 32'd0); check("mr.r31", rt0, 32'd0); check("mr.r7", dbg0, 32'd0);
        check("mr.r3b", rs1, 32'd0);

        // Randomized traffic; addresses biased toward the write target and $31.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 99) == 0);
            set_wr(1'($urandom_range(0, 3) != 0), wa, $urandom, 1'($urandom_range(0, 3) == 0), $urandom);
            rs_addr  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            rt_addr  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            dbg_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
            #1;
            check_all("rnd");
            tick();
        end

        rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i), 5'(i));
            check_all("final");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
